cim_column_array_bs: RTL and testbench

Bit-serial compute-in-memory tile: a NUM_ROWS × NUM_COLS array of register-stored signed weights. It accepts one activation vector per transaction and computes NUM_COLS dot products by streaming activation bit-planes LSB-first with shift-and-accumulate. It is the multi-column successor of the single-column CIM datapath and sits between the activation buffer and the partial-sum accumulator. Signed and unsigned activation modes and valid/ready handshakes are provided on both sides.

---
 rtl/cim_column_array_bs_pkg.sv | 32 +++
 rtl/cim_column_array_bs_if.sv | 39 +++
 rtl/cim_column_array_bs_plane_sum.sv | 27 ++
 rtl/cim_column_array_bs.sv | 138 +++++++++++++
 tb/tb_cim_column_array_bs.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cim_column_array_bs_pkg.sv
// cim_pkg: state encoding, width helpers and lane-slicing helpers shared by the bit-serial CIM tile.
// Revision 1.0
`default_nettype none

package cim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } cim_state_e;

  function automatic int sum_width(input int w_width, input int num_rows);
    return w_width + $clog2(num_rows) + 1;
  endfunction

  function automatic int acc_width(input int w_width, input int num_rows, input int act_width);
    return sum_width(w_width, num_rows) + act_width;
  endfunction

  function automatic int cnt_width(input int act_width);
    return (act_width > 1) ? $clog2(act_width) : 1;
  endfunction

  // Packed buses put lane idx at [idx*width +: width].
  function automatic int lane_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cim_column_array_bs_if.sv
// cim_column_array_bs_if: weight-write, activation-in and result-out bundle for the CIM tile.
// Revision 1.0
`default_nettype none

interface cim_column_array_bs_if
  import cim_pkg::*;
#(
  parameter int NUM_ROWS  = 32,
  parameter int NUM_COLS  = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACT_WIDTH = 8
) ();
  localparam int ACC_WIDTH = acc_width(W_WIDTH, NUM_ROWS, ACT_WIDTH);

  logic                          wr_en;
  logic [$clog2(NUM_ROWS)-1:0]   wr_row;
  logic [NUM_COLS*W_WIDTH-1:0]   wr_data;
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_ROWS*ACT_WIDTH-1:0] in_act;
  logic                          act_signed;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_COLS*ACC_WIDTH-1:0] out_data;
  logic                          busy;

  modport slave (
    input  wr_en, wr_row, wr_data, in_valid, in_act, act_signed, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output wr_en, wr_row, wr_data, in_valid, in_act, act_signed, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/cim_column_array_bs_plane_sum.sv
// cim_plane_sum: combinational sum of one column's weights gated by one activation bit-plane.
// Revision 1.0
`default_nettype none

module cim_plane_sum #(
  parameter int NUM_ROWS  = 32,
  parameter int W_WIDTH   = 8,
  parameter int SUM_WIDTH = 14
) (
  input  wire logic [NUM_ROWS*W_WIDTH-1:0] i_w,
  input  wire logic [NUM_ROWS-1:0]         i_bits,
  output logic signed [SUM_WIDTH-1:0]      o_sum
);

  always_comb begin
    o_sum = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (i_bits[r]) begin
        o_sum = o_sum + {{(SUM_WIDTH-W_WIDTH){i_w[r*W_WIDTH+W_WIDTH-1]}},
                         i_w[r*W_WIDTH +: W_WIDTH]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cim_column_array_bs.sv
// cim_column_array_bs: NUM_ROWS x NUM_COLS bit-serial CIM tile, LSB-first shift-and-accumulate.
// Optional CIM_RELU_EN clamps negative column results to zero on entry to DONE. Revision 1.0
`default_nettype none

module cim_column_array_bs
  import cim_pkg::*;
#(
  parameter int NUM_ROWS  = 32,
  parameter int NUM_COLS  = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACT_WIDTH = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  cim_column_array_bs_if.slave   bus
);
  localparam int SUM_WIDTH = sum_width(W_WIDTH, NUM_ROWS);
  localparam int ACC_WIDTH = acc_width(W_WIDTH, NUM_ROWS, ACT_WIDTH);
  localparam int CNT_WIDTH = cnt_width(ACT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_LAST_BIT = CNT_WIDTH'(ACT_WIDTH - 1);

  cim_state_e                    r_state;
  cim_state_e                    w_state_nxt;
  logic [NUM_COLS*W_WIDTH-1:0]   r_w [NUM_ROWS];
  logic [NUM_ROWS*ACT_WIDTH-1:0] r_act;
  logic                          r_sgn;
  logic [CNT_WIDTH-1:0]          r_bit;
  logic [NUM_ROWS-1:0]           w_bits;
  logic                          w_accept;
  logic                          w_last;
  logic                          w_wr_ok;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_last   = (r_bit == c_LAST_BIT);
  assign w_wr_ok  = bus.wr_en && (r_state != ST_COMPUTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (bus.in_valid) w_state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:    if (bus.out_ready) w_state_nxt = bus.in_valid ? ST_COMPUTE : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      ST_IDLE:    bus.in_ready = 1'b1;
      ST_COMPUTE: bus.busy = 1'b1;
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  // Writes in the accept cycle land before the first bit-plane is read next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_ROWS; r++) r_w[r] <= '0;
    end else if (w_wr_ok) begin
      r_w[bus.wr_row] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act <= '0;
      r_sgn <= 1'b0;
      r_bit <= '0;
    end else if (w_accept) begin
      r_act <= bus.in_act;
      r_sgn <= bus.act_signed;
      r_bit <= '0;
    end else if (r_state == ST_COMPUTE && !w_last) begin
      r_bit <= r_bit + 1'b1;
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic [ACT_WIDTH-1:0] w_a;
    assign w_a       = r_act[lane_lo(r, ACT_WIDTH) +: ACT_WIDTH];
    assign w_bits[r] = w_a[r_bit];
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [NUM_ROWS*W_WIDTH-1:0]  w_colw;
    logic signed [SUM_WIDTH-1:0]  w_psum;
    logic signed [ACC_WIDTH-1:0]  w_term;
    logic signed [ACC_WIDTH-1:0]  w_next;
    logic signed [ACC_WIDTH-1:0]  r_acc;

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_gather
      assign w_colw[lane_lo(r, W_WIDTH) +: W_WIDTH] = r_w[r][lane_lo(c, W_WIDTH) +: W_WIDTH];
    end

    cim_plane_sum #(
      .NUM_ROWS (NUM_ROWS),
      .W_WIDTH  (W_WIDTH),
      .SUM_WIDTH(SUM_WIDTH)
    ) u_plane_sum (
      .i_w   (w_colw),
      .i_bits(w_bits),
      .o_sum (w_psum)
    );

    assign w_term = ACC_WIDTH'(w_psum) <<< r_bit;

    // The MSB plane of a two's-complement activation carries negative weight.
    always_comb begin
      w_next = (w_last && r_sgn) ? (r_acc - w_term) : (r_acc + w_term);
`ifdef CIM_RELU_EN
      if (w_last && (w_next < 0)) w_next = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_acc <= '0;
      else if (w_accept)              r_acc <= '0;
      else if (r_state == ST_COMPUTE) r_acc <= w_next;
    end

    assign bus.out_data[lane_lo(c, ACC_WIDTH) +: ACC_WIDTH] = r_acc;
  end

endmodule

`default_nettype wire

// File: tb/tb_cim_column_array_bs.sv
// tb_cim_column_array_bs: directed plus random checks of the 4x2 CIM tile against a dot-product model.
// Revision 1.0
`default_nettype none

module tb_cim_column_array_bs;
  localparam int NR  = 4;
  localparam int NC  = 2;
  localparam int WW  = 8;
  localparam int AW  = 4;
  localparam int ACC = WW + $clog2(NR) + 1 + AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wm [NR][NC];
  int   e0, e1;

  always #5 clk = ~clk;

  cim_column_array_bs_if #(.NUM_ROWS(NR), .NUM_COLS(NC), .W_WIDTH(WW), .ACT_WIDTH(AW)) bus ();

  cim_column_array_bs #(.NUM_ROWS(NR), .NUM_COLS(NC), .W_WIDTH(WW), .ACT_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic signed [ACC-1:0] o0, o1;
  assign o0 = bus.out_data[0 +: ACC];
  assign o1 = bus.out_data[ACC +: ACC];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int c, input logic [NR*AW-1:0] acts, input bit sgn);
    int s = 0;
    logic [AW-1:0] a;
    int v;
    for (int r = 0; r < NR; r++) begin
      a = acts[r*AW +: AW];
      v = (sgn && a[AW-1]) ? int'(a) - (1 << AW) : int'(a);
      s += wm[r][c] * v;
    end
`ifdef CIM_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic mwrite(input int row, input logic [NC*WW-1:0] d);
    logic [WW-1:0] b;
    for (int c = 0; c < NC; c++) begin
      b = d[c*WW +: WW];
      wm[row][c] = int'($signed(b));
    end
  endtask

  task automatic mclear();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) wm[r][c] = 0;
  endtask

  task automatic write_row(input int row, input logic [NC*WW-1:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_row = row[1:0]; bus.wr_data = d;
    mwrite(row, d);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic start(input logic [NR*AW-1:0] acts, input bit sgn,
                       input bit dowr, input int row, input logic [NC*WW-1:0] d);
    @(negedge clk);
    bus.in_act = acts; bus.act_signed = sgn; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    if (dowr) begin
      bus.wr_en = 1'b1; bus.wr_row = row[1:0]; bus.wr_data = d;
      mwrite(row, d);
    end
    e0 = model(0, acts, sgn);
    e1 = model(1, acts, sgn);
    #1 chk("accept_in_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.wr_en = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    chk("no_valid_after_accept", bus.out_valid, 0);
  endtask

  task automatic wait_done();
    int early = 0;
    for (int i = 1; i <= AW; i++) begin
      @(negedge clk);
      if (i < AW && bus.out_valid) early++;
    end
    chk("latency_early", early, 0);
    chk("latency_valid", bus.out_valid, 1);
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_col0"}, o0, e0);
    chk({tag, "_col1"}, o1, e1);
  endtask

  task automatic run(input string tag, input logic [NR*AW-1:0] acts, input bit sgn);
    start(acts, sgn, 1'b0, 0, '0);
    wait_done();
    check_out(tag);
  endtask

  initial begin
    int vcount;
    logic [NR*AW-1:0] ra;
    logic [NC*WW-1:0] rd;
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0;
    bus.in_valid = 1'b0; bus.in_act = '0; bus.act_signed = 1'b0; bus.out_ready = 1'b1;
    mclear();

    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);

    for (int r = 0; r < NR; r++) write_row(r, {8'(r + 1), 8'h01});
    run("acts3_unsigned", 16'h3333, 1'b0);
    run("actsF_signed", 16'hFFFF, 1'b1);
    run("actsF_unsigned", 16'hFFFF, 1'b0);

    for (int r = 0; r < NR; r++) write_row(r, 16'h8080);
    run("neg8_signed", 16'h8888, 1'b1);
    run("pos7_unsigned", 16'h7777, 1'b0);

    start(16'h1111, 1'b0, 1'b1, 0, 16'h0505);
    wait_done();
    check_out("write_with_accept");

    for (int r = 0; r < NR; r++) write_row(r, {8'(r + 1), 8'h01});

    start(16'h3333, 1'b0, 1'b0, 0, '0);
    bus.out_ready = 1'b0;
    wait_done();
    check_out("hold_first");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.wr_en = (k == 2);
      if (k == 2) begin
        bus.wr_row = 2'd3; bus.wr_data = 16'h0202;
        mwrite(3, 16'h0202);
      end
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      check_out("hold_stable");
    end
    bus.wr_en = 1'b0;
    start(16'h2121, 1'b0, 1'b0, 0, '0);
    wait_done();
    check_out("back_to_back");

    start(16'h5A3C, 1'b0, 1'b0, 0, '0);
    bus.wr_en = 1'b1; bus.wr_row = 2'd0; bus.wr_data = 16'h7F7F;
    wait_done();
    bus.wr_en = 1'b0;
    check_out("compute_write_cur");
    run("compute_write_next", 16'hC3A5, 1'b1);

    start(16'hFFFF, 1'b0, 1'b0, 0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    mclear();
    #1;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_data", bus.out_data, 0);
    #2 rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("abort_no_result", vcount, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    run("after_abort_zero_w", 16'h9F6E, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = NR*AW'($urandom);
      rd = NC*WW'($urandom);
      start(ra, 1'($urandom), 1'($urandom), int'($urandom_range(NR - 1, 0)), rd);
      wait_done();
      check_out("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
